// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch-predictor definitions: PC width, sequential PC increment and
// the prediction FIFO entry layout.
package branch_resolve_unit_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;

  // One fetched-but-unresolved prediction.
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pred_pc;
  } pred_entry_t;

endpackage

// File: rtl/branch_resolve_unit_pred_fifo.sv
// pred_fifo: in-order FIFO of fetched predictions with push, pop and flush.
// Flush has priority over push/pop; a push while full only lands when a pop
// frees the head in the same cycle.
module pred_fifo
  import branch_resolve_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        flush_i,
  input  pred_entry_t wdata_i,
  output pred_entry_t head_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  pred_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Next pointer/occupancy: flush empties, otherwise advance per push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; data is not reset, occupancy decides validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: compares each EX-stage instruction against the oldest
// outstanding fetch prediction, redirects fetch on a mismatch and reports
// resolved control transfers to the predictor one cycle later.
// Optional feature macro BRU_STATS_EN adds saturating ctrl/mispredict counters.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_valid,
  input  logic [PC_W-1:0] fetch_pc,
  input  logic [PC_W-1:0] fetch_pred_pc,
  output logic            fifo_full,
  input  logic            ex_valid,
  input  logic            ex_is_ctrl,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            update_pred,
  output logic [PC_W-1:0] branch_inst_address,
  output logic [PC_W-1:0] resolved_next_pc,
  output logic            predictor_wrong,
`ifdef BRU_STATS_EN
  output logic [31:0]     ctrl_count,
  output logic [31:0]     mispredict_count,
`endif
  output logic            proto_err
);

  pred_entry_t     head;
  logic            fifo_empty;
  logic            resolve, pc_mismatch, pred_miss, push_req, push_en;
  logic [PC_W-1:0] actual_next;
  logic            upd_q, upd_d, wrong_q, proto_q, proto_d;
  logic [PC_W-1:0] addr_q, next_q;

  pred_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_en),
    .pop_i   (resolve),
    .flush_i (redirect),
    .wdata_i ('{pc: fetch_pc, pred_pc: fetch_pred_pc}),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Resolution and comparison against the FIFO head.
  always_comb begin
    actual_next = (ex_is_ctrl && ex_taken) ? ex_target : ex_pc + PC_INC;
    resolve     = ex_valid && !fifo_empty;
    pc_mismatch = (ex_pc != head.pc);
    pred_miss   = (actual_next != head.pred_pc);
    redirect    = !reset && resolve && (pc_mismatch || pred_miss);
    redirect_pc = reset ? '0 : actual_next;
    push_req    = fetch_valid && !redirect;
    push_en     = push_req && (!fifo_full || resolve);
    upd_d       = resolve && ex_is_ctrl;
    proto_d     = proto_q
                | (ex_valid && fifo_empty)
                | (resolve && pc_mismatch)
                | (push_req && fifo_full && !resolve);
  end

  // Registered predictor-update bus and sticky protocol flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      upd_q   <= 1'b0;
      wrong_q <= 1'b0;
      addr_q  <= '0;
      next_q  <= '0;
      proto_q <= 1'b0;
    end else begin
      upd_q   <= upd_d;
      proto_q <= proto_d;
      if (upd_d) begin
        wrong_q <= pred_miss;
        addr_q  <= ex_pc;
        next_q  <= actual_next;
      end
    end
  end

  assign update_pred         = upd_q;
  assign predictor_wrong     = wrong_q;
  assign branch_inst_address = addr_q;
  assign resolved_next_pc    = next_q;
  assign proto_err           = proto_q;

`ifdef BRU_STATS_EN
  logic [31:0] ctrl_cnt_q, mis_cnt_q;

  // Saturating counters of reported updates and mispredictions.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_cnt_q <= '0;
      mis_cnt_q  <= '0;
    end else if (upd_q) begin
      if (ctrl_cnt_q != '1) ctrl_cnt_q <= ctrl_cnt_q + 32'd1;
      if (wrong_q && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign ctrl_count       = ctrl_cnt_q;
  assign mispredict_count = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: a queue-based reference model
// predicts same-cycle outputs and pushes expected predictor updates, which a
// separate monitor pops and compares whenever update_pred is seen.
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, fetch_valid, ex_valid, ex_is_ctrl, ex_taken;
  logic [31:0] fetch_pc, fetch_pred_pc, ex_pc, ex_target;
  logic        fifo_full, redirect, update_pred, predictor_wrong, proto_err;
  logic [31:0] redirect_pc, branch_inst_address, resolved_next_pc;
`ifdef BRU_STATS_EN
  logic [31:0] ctrl_count, mispredict_count;
`endif

  branch_resolve_unit #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_pred_pc(fetch_pred_pc),
    .fifo_full(fifo_full),
    .ex_valid(ex_valid), .ex_is_ctrl(ex_is_ctrl), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .update_pred(update_pred), .branch_inst_address(branch_inst_address),
    .resolved_next_pc(resolved_next_pc), .predictor_wrong(predictor_wrong),
`ifdef BRU_STATS_EN
    .ctrl_count(ctrl_count), .mispredict_count(mispredict_count),
`endif
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] pred; } pred_t;
  typedef struct { int due; logic [31:0] addr; logic [31:0] nxt; logic wrong; } upd_t;

  pred_t mq[$];   // model of outstanding predictions, oldest first
  upd_t  sb[$];   // expected predictor updates
  bit    m_proto;
  int    cyc = 0;
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check same-cycle outputs, advance the model.
  task automatic step(input bit rst, input bit fv, input logic [31:0] fpc, input logic [31:0] fpred,
                      input bit ev, input bit ctrl, input logic [31:0] epc,
                      input bit tk, input logic [31:0] tgt);
    bit          empty, full, active, red;
    logic [31:0] actual;
    @(negedge clk);
    reset = rst; fetch_valid = fv; fetch_pc = fpc; fetch_pred_pc = fpred;
    ex_valid = ev; ex_is_ctrl = ctrl; ex_pc = epc; ex_taken = tk; ex_target = tgt;
    #1;
    empty  = (mq.size() == 0);
    full   = (mq.size() == DEPTH);
    actual = (ctrl && tk) ? tgt : epc + 32'd4;
    active = !rst && ev && !empty;
    red    = active && ((epc != mq[0].pc) || (actual != mq[0].pred));
    check("redirect", {31'b0, redirect}, {31'b0, red});
    check("redirect_pc", redirect_pc, rst ? 32'h0 : actual);
    check("fifo_full", {31'b0, fifo_full}, {31'b0, full});
    check("proto_err", {31'b0, proto_err}, {31'b0, m_proto});
    if (rst) begin
      mq.delete();
      m_proto = 1'b0;
    end else begin
      if ((ev && empty) || (active && epc != mq[0].pc) || (fv && !red && full && !active))
        m_proto = 1'b1;
      if (active && ctrl)
        sb.push_back('{due: cyc + 1, addr: epc, nxt: actual, wrong: (actual != mq[0].pred)});
      if (red) mq.delete();
      else begin
        if (active) void'(mq.pop_front());
        if (fv && (!full || active)) mq.push_back('{pc: fpc, pred: fpred});
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] pred);
    step(0, 1, pc, pred, 0, 0, 0, 0, 0);
  endtask

  task automatic ex(input bit ctrl, input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    step(0, 0, 0, 0, 1, ctrl, pc, tk, tgt);
  endtask

  // Monitor: pops an expectation whenever the DUT reports an update.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      if (update_pred === 1'b1) begin
        if (sb.size() == 0 || sb[0].due != cyc) begin
          check("update_pred_unexpected", 32'd1, 32'd0);
        end else begin
          check("branch_inst_address", branch_inst_address, sb[0].addr);
          check("resolved_next_pc", resolved_next_pc, sb[0].nxt);
          check("predictor_wrong", {31'b0, predictor_wrong}, {31'b0, sb[0].wrong});
          void'(sb.pop_front());
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        check("update_pred_missing", {31'b0, update_pred}, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] fpc, epc, tgt;
    reset = 1'b1; fetch_valid = 0; fetch_pc = 0; fetch_pred_pc = 0;
    ex_valid = 0; ex_is_ctrl = 0; ex_pc = 0; ex_taken = 0; ex_target = 0;
    m_proto = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    check("reset_update_pred", {31'b0, update_pred}, 32'd0);

    // Non-control, correctly predicted.
    push(32'h100, 32'h104);
    ex(0, 32'h100, 0, 32'h0);
    idle(2);
    // Taken branch, predicted fall-through.
    push(32'h200, 32'h204);
    ex(1, 32'h200, 1, 32'h300);
    idle(2);
    // Taken branch, correctly predicted.
    push(32'h400, 32'h480);
    ex(1, 32'h400, 1, 32'h480);
    idle(2);
    // Sequential wrap-around at the top of the address space.
    push(32'hFFFF_FFFC, 32'h0);
    ex(0, 32'hFFFF_FFFC, 0, 32'h0);
    idle(1);
    // Fill, push with pop while full, then push while full without pop.
    for (int i = 0; i < DEPTH; i++) push(32'h500 + 32'(4 * i), 32'h504 + 32'(4 * i));
    step(0, 1, 32'h510, 32'h514, 1, 0, 32'h500, 0, 0);
    push(32'h514, 32'h518);
    for (int i = 1; i <= DEPTH; i++) ex(0, 32'h500 + 32'(4 * i), 0, 0);
    idle(1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // EX with empty FIFO.
    ex(1, 32'h700, 1, 32'h900);
    idle(1);
    // Reset in the middle of traffic, with concurrent push and pop.
    push(32'h800, 32'h804);
    push(32'h804, 32'h900);
    ex(1, 32'h800, 0, 32'h0);
    step(1, 1, 32'h808, 32'h80C, 1, 1, 32'h804, 1, 32'h950);
    idle(1);
    check("post_reset_update_pred", {31'b0, update_pred}, 32'd0);
    check("post_reset_addr", branch_inst_address, 32'h0);
    check("post_reset_next", resolved_next_pc, 32'h0);
    check("post_reset_wrong", {31'b0, predictor_wrong}, 32'd0);
    check("post_reset_proto", {31'b0, proto_err}, 32'd0);

    // Three branches, one mispredicted.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    push(32'h600, 32'h604);
    ex(1, 32'h600, 0, 32'h0);
    push(32'h700, 32'h780);
    ex(1, 32'h700, 1, 32'h780);
    push(32'hA00, 32'hA04);
    ex(1, 32'hA00, 1, 32'hB00);
    idle(3);
`ifdef BRU_STATS_EN
    check("ctrl_count", ctrl_count, 32'd3);
    check("mispredict_count", mispredict_count, 32'd1);
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      fpc = {$urandom_range(0, 255), 2'b00} << 2;
      if (mq.size() > 0 && $urandom_range(0, 15) != 0) epc = mq[0].pc;
      else epc = {$urandom_range(0, 255), 2'b00} << 2;
      if (mq.size() > 0 && $urandom_range(0, 1) == 1) tgt = mq[0].pred;
      else tgt = {$urandom_range(0, 255), 2'b00} << 2;
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 1) == 1, fpc,
           ($urandom_range(0, 1) == 1) ? fpc + 32'd4 : {$urandom_range(0, 255), 4'b0000},
           $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, epc,
           $urandom_range(0, 1) == 1, tgt);
    end
    idle(4);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
